// File: rtl/im_pkg.sv
// Shared constants for the instruction-memory loader.
//   IM_ADDR_W : byte-address width of the 1 KB instruction memory
//   IM_WORDS  : capacity in 32-bit words (2**(IM_ADDR_W-2))
//   ST_*      : loader FSM state encoding
package im_pkg;

  localparam int IM_ADDR_W = 10;
  localparam int IM_WORDS  = 256;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/im_loader_word_packer.sv
// word_packer: packs accepted bytes big-endian into a 32-bit word.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart at lane 0 with an empty word (new load)
//   accept      : a byte is consumed this cycle
//   byte_data   : the byte being consumed
//   byte_last   : the consumed byte is the final byte of the image
//   word        : packed word including this byte (zero-padded on last)
//   word_ready  : this accept completes a word (lane 3 or last byte)
//   pad_last    : this accept completes a word early and zero-pads it
module word_packer
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic [31:0] word,
  output logic        word_ready,
  output logic        pad_last
);

  logic [1:0]  lane_reg;
  logic [31:0] shift_reg;
  logic [31:0] shift_next;

  // Each byte lane either takes the incoming byte, is wiped when a new
  // word starts at lane 0 (this is what zero-pads a short final word and
  // keeps stale bytes out), or keeps its previous contents.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        if (lane_reg == 2'(gi))
          shift_next[31-8*gi -: 8] = byte_data;
        else if (lane_reg == 2'd0)
          shift_next[31-8*gi -: 8] = 8'h00;
        else
          shift_next[31-8*gi -: 8] = shift_reg[31-8*gi -: 8];
      end
    end
  endgenerate

  assign word       = shift_next;
  assign word_ready = accept & ((lane_reg == 2'd3) | byte_last);
  assign pad_last   = accept & byte_last & (lane_reg != 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_reg  <= 2'd0;
      shift_reg <= 32'h0;
    end else if (accept) begin
      shift_reg <= shift_next;
      lane_reg  <= word_ready ? 2'd0 : lane_reg + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// im_loader: turns a valid/ready byte stream into word writes for the
// 1 KB instruction memory, starting at byte address 0.
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle pulse starting a load (from IDLE or DONE)
//   byte_valid   : byte_data valid
//   byte_data    : stream byte, first byte lands in wdata[31:24]
//   byte_last    : final byte of the image
//   byte_ready   : loader accepts a byte this cycle
//   we           : IM write strobe, one cycle per word
//   waddr        : word-aligned IM byte address
//   wdata        : packed word (qualify with we)
//   busy         : load in progress
//   done         : load complete, held until start or rst
//   full         : memory filled before byte_last was seen
//   word_count   : words written in the current load (saturates at WORDS)
module im_loader
  import im_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int WORDS  = IM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W-2:0] word_count
);

  localparam logic [ADDR_W-2:0] LAST_WORD = (ADDR_W-1)'(WORDS - 1);
  localparam logic [ADDR_W-2:0] MAX_COUNT = (ADDR_W-1)'(WORDS);

  logic [1:0]        state_reg;
  logic [ADDR_W-2:0] word_count_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [31:0]       wdata_reg;
  logic              full_reg;
  logic              last_reg;   // byte_last already consumed in this load

  logic        accept;
  logic        clear;
  logic [31:0] packed_word;
  logic        word_ready;
  logic        pad_last;

  assign accept = byte_valid & (state_reg == ST_LOAD);
  // start is honoured only when no load is running
  assign clear  = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .word       (packed_word),
    .word_ready (word_ready),
    .pad_last   (pad_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      word_count_reg <= '0;
      waddr_reg      <= '0;
      wdata_reg      <= '0;
      full_reg       <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg      <= ST_LOAD;
            word_count_reg <= '0;
            full_reg       <= 1'b0;
            last_reg       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept && byte_last)
            last_reg <= 1'b1;
          // Capture the word and its address on the completing byte so
          // they are stable during the WRITE cycle and held afterwards.
          if (word_ready) begin
            state_reg <= ST_WRITE;
            wdata_reg <= packed_word;
            waddr_reg <= {word_count_reg[ADDR_W-3:0], 2'b00};
          end
        end
        ST_WRITE: begin
          if (word_count_reg != MAX_COUNT)
            word_count_reg <= word_count_reg + 1'b1;
          if (last_reg || (word_count_reg == LAST_WORD))
            state_reg <= ST_DONE;
          else
            state_reg <= ST_LOAD;
          if ((word_count_reg == LAST_WORD) && !last_reg)
            full_reg <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = (state_reg == ST_LOAD);
  assign we         = (state_reg == ST_WRITE);
  assign busy       = (state_reg == ST_LOAD) | (state_reg == ST_WRITE);
  assign done       = (state_reg == ST_DONE);
  assign full       = full_reg;
  assign waddr      = waddr_reg;
  assign wdata      = wdata_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_im_loader.sv
// Directed testbench for im_loader. A negedge monitor logs each IM write
// into queues and into a model 256-word memory for read-back checks.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_last = 1'b0;
  logic        byte_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        full;
  logic [8:0]  word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] mem [0:255];
  logic        quiet = 1'b0;

  im_loader #(.ADDR_W(10), .WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      wr_addr_q.push_back(waddr);
      wr_data_q.push_back(wdata);
      mem[waddr[9:2]] = wdata;
      if (!quiet)
        $display("write addr=0x%03h data=0x%08h", waddr, wdata);
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    byte_valid = 1'b1; byte_data = d; byte_last = l;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_byte timeout: byte_ready=%0b required 1", byte_ready);
        break;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: done=%0b required 1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({byte_ready, we, busy, done, full} !== 5'b0 || waddr !== 10'h0 ||
        wdata !== 32'h0 || word_count !== 9'd0) begin
      n_fail++;
      $display("FAIL reset: rdy=%0b we=%0b busy=%0b done=%0b full=%0b addr=%h data=%h cnt=%0d required all 0",
               byte_ready, we, busy, done, full, waddr, wdata, word_count);
    end
  endtask

  task automatic test_two_words();
    clear_log();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL two_words busy: busy=%0b rdy=%0b required 1 1", busy, byte_ready);
    end
    for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7);
    wait_done();
    n_checks++;
    if (wr_addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL two_words count: writes=%0d required 2", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 10'h000 || wr_data_q[0] !== 32'h00010203 ||
                 wr_addr_q[1] !== 10'h004 || wr_data_q[1] !== 32'h04050607) begin
      n_fail++;
      $display("FAIL two_words data: (%h,%h)(%h,%h) required (000,00010203)(004,04050607)",
               wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
    end
    n_checks++;
    if (word_count !== 9'd2 || full !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL two_words status: cnt=%0d full=%0b rdy=%0b busy=%0b required 2 0 0 0",
               word_count, full, byte_ready, busy);
    end
    // valid in DONE must be ignored
    byte_valid = 1'b1; byte_data = 8'h5A;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    n_checks++;
    if (wr_addr_q.size() != 2 || done !== 1'b1 || wdata !== 32'h04050607) begin
      n_fail++;
      $display("FAIL done_ignores_valid: writes=%0d done=%0b data=%h required 2 1 04050607",
               wr_addr_q.size(), done, wdata);
    end
  endtask

  task automatic test_pad();
    clear_log();
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || word_count !== 9'd0) begin
      n_fail++;
      $display("FAIL pad restart: done=%0b cnt=%0d required 0 0", done, word_count);
    end
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    n_checks++;
    if (we !== 1'b1) begin
      n_fail++;
      $display("FAIL pad latency: we=%0b required 1", we);
    end
    wait_done();
    n_checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 10'h000 || wr_data_q[0] !== 32'hAABBCC00 ||
        word_count !== 9'd1) begin
      n_fail++;
      $display("FAIL pad data: writes=%0d cnt=%0d data=%h required 1 1 AABBCC00",
               wr_addr_q.size(), word_count, wdata);
    end
  endtask

  task automatic test_mem_image();
    logic [31:0] exp;
    int bad;
    clear_log();
    pulse_start();
    for (int i = 0; i < 40; i++) send_byte(8'(i), i == 39);
    wait_done();
    bad = 0;
    exp = 32'h00010203;
    for (int w = 0; w < 10; w++) begin
      n_checks++;
      if (mem[w] !== exp) begin
        n_fail++; bad++;
        $display("FAIL mem_image word %0d: got %h required %h", w, mem[w], exp);
      end
      exp = exp + 32'h04040404;
    end
    n_checks++;
    if (word_count !== 9'd10 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_image status: cnt=%0d full=%0b required 10 0", word_count, full);
    end
  endtask

  task automatic test_full();
    clear_log();
    quiet = 1'b1;
    pulse_start();
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b0);
    wait_done();
    quiet = 1'b0;
    $display("full load: %0d writes logged", wr_addr_q.size());
    n_checks++;
    if (wr_addr_q.size() != 256) begin
      n_fail++;
      $display("FAIL full writes: got %0d required 256", wr_addr_q.size());
    end else if (wr_addr_q[255] !== 10'h3FC || wr_data_q[255] !== 32'hFCFDFEFF ||
                 wr_data_q[0] !== 32'h00010203) begin
      n_fail++;
      $display("FAIL full data: last (%h,%h) first %h required (3FC,FCFDFEFF) 00010203",
               wr_addr_q[255], wr_data_q[255], wr_data_q[0]);
    end
    n_checks++;
    if (full !== 1'b1 || done !== 1'b1 || word_count !== 9'd256 || waddr !== 10'h3FC) begin
      n_fail++;
      $display("FAIL full status: full=%0b done=%0b cnt=%0d addr=%h required 1 1 256 3FC",
               full, done, word_count, waddr);
    end
    byte_valid = 1'b1; byte_data = 8'h77;
    repeat (4) @(negedge clk);
    n_checks++;
    if (byte_ready !== 1'b0 || wr_addr_q.size() != 256 || word_count !== 9'd256) begin
      n_fail++;
      $display("FAIL full extra byte: rdy=%0b writes=%0d cnt=%0d required 0 256 256",
               byte_ready, wr_addr_q.size(), word_count);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_gaps();
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i), i == 7);
      if (i == 5) pulse_start();       // ignored while loading
      else if (i != 7) begin @(posedge clk); #1; end
    end
    wait_done();
    n_checks++;
    if (wr_addr_q.size() != 2 || wr_data_q[0] !== 32'h00010203 || wr_data_q[1] !== 32'h04050607 ||
        wr_addr_q[1] !== 10'h004) begin
      n_fail++;
      $display("FAIL gaps data: writes=%0d data=%h required 2 writes 00010203,04050607",
               wr_addr_q.size(), wdata);
    end
    n_checks++;
    if (word_count !== 9'd2 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps count: cnt=%0d full=%0b required 2 0", word_count, full);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({byte_ready, we, busy, done, full} !== 5'b0 || waddr !== 10'h0 ||
        wdata !== 32'h0 || word_count !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%0b we=%0b busy=%0b done=%0b full=%0b addr=%h data=%h cnt=%0d required all 0",
               byte_ready, we, busy, done, full, waddr, wdata, word_count);
    end
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    wait_done();
    n_checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 10'h000 || wr_data_q[0] !== 32'h11223344) begin
      n_fail++;
      $display("FAIL reset_mid reload: writes=%0d data=%h required 1 11223344",
               wr_addr_q.size(), wdata);
    end
  endtask

  task automatic test_start_rst();
    @(posedge clk); #1 start = 1'b1; rst = 1'b1;
    @(posedge clk); #1 start = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL start_rst: busy=%0b done=%0b rdy=%0b required 0 0 0", busy, done, byte_ready);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_pad();
    test_mem_image();
    test_full();
    test_gaps();
    test_reset_mid();
    test_start_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
Writer-side companion to the 1 KB instruction memory (im_1k).
- Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words: the first byte goes to bits [31:24].
- Emits one word-write per packed word into the IM write port, at consecutive word-aligned byte addresses starting at 0.
- Used by bench and boot logic to load programs in place of $readmemh.

Parameters:
ADDR_W, 10, byte-address width of the IM (1 KB).
WORDS, 256, IM capacity in words; must equal 2**(ADDR_W-2).

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a load.
byte_valid  in  1  byte_data is valid this cycle.
byte_data  in  8  stream byte.
byte_last  in  1  qualifies the final byte of the image; sampled only with valid&ready.
byte_ready  out  1  loader accepts a byte this cycle.
we  out  1  IM write strobe, one cycle per word.
waddr  out  ADDR_W  IM byte address; always has bits [1:0] = 0.
wdata  out  32  packed word.
busy  out  1  a load is in progress (LOAD or WRITE state).
done  out  1  load complete; held until the next start or rst.
full  out  1  all WORDS words were written before byte_last was seen.
word_count  out  ADDR_W-1  number of words written in the current load.

Behaviour:
- Reset: state=IDLE; all outputs 0; byte-lane counter 0; shift register 0. A reset mid-load discards any partial word, and the IM contents written so far are left as they are.
- A byte is accepted when byte_valid & byte_ready at a rising edge.
- States:
  - IDLE: byte_ready=0. start -> LOAD; clears word_count, lane, done, full.
  - LOAD: byte_ready=1. On each accepted byte, shift it into lane 0..3 (MSB first) and increment lane.
    - Accepting lane-3 byte, or byte_last on any lane -> WRITE.
    - If byte_last arrives on lane k<3, lanes k+1..3 are zero-padded.
    - Without valid, stay in LOAD; there is no timeout.
  - WRITE: exactly one cycle; byte_ready=0.
    - we=1; waddr={word_count,2'b00}; wdata=packed word.
    - At the edge: word_count+1, lane=0.
    - Next state is DONE if the last byte was byte_last, or if word_count was WORDS-1. Otherwise LOAD.
    - full=1 if the WORDS-1 case is reached and byte_last was not seen.
  - DONE: byte_ready=0; done=1; byte_valid is ignored. start -> LOAD with a fresh clear.
- Latency:
  - The byte accepted at edge N appears as we=1 in the cycle after edge N.
  - Sustained throughput is 4 bytes per 5 cycles.
- start while in LOAD or WRITE is ignored.
- start and rst together: rst wins.
- word_count saturates at WORDS. Its width (ADDR_W-1 bits) holds the value WORDS, so waddr never wraps.
- wdata and waddr hold their last values when we=0. Consumers must qualify them with we.
- busy is 1 in LOAD and WRITE, else 0.

Decomposition:
- Shared package im_pkg: IM_ADDR_W=10, IM_WORDS=256, and the state encoding {IDLE, LOAD, WRITE, DONE} as localparams.
- One natural sub-module: word_packer, containing the lane counter and 32-bit shift register, with outputs word_ready and pad-on-last.
- The FSM and address counter stay in im_loader.

Test Plan:
- start; bytes 00..07 with byte_last on 07, valid every cycle -> two writes: (0x000, 32'h00010203) then (0x004, 32'h04050607); done=1; word_count=2; full=0; byte_ready=0 afterwards.
- start; bytes AA, BB, CC with last on CC -> single write (0x000, 32'hAABBCC00); done=1; word_count=1.
- Integration with im_1k: load 40 bytes 00..27, last on 27. Then read addr 0,4,...,36 -> dout 32'h00010203, incrementing by 32'h04040404 each word; 10 matches.
- 1024 bytes without byte_last -> 256 writes; final waddr=0x3FC; full=1; done=1; word_count=256. A further byte_valid is not accepted.
- Backpressure and gaps: byte_valid toggling every other cycle; a start pulse during LOAD -> packed data is identical to the gap-free run; the start is ignored, so word_count is not cleared.
- Reset mid-word: 2 bytes, then rst for 1 cycle -> all outputs 0, state IDLE. start; bytes 11 22 33 44 last -> write (0x000, 32'h11223344), with no residue from before the reset.
